// File: rtl/alu_operand_queue.sv
// Two-entry operand staging queue between decode and the execute-stage ALUs.
// Buffered operands snoop the result-forwarding bus; the head carries a precomputed SHFL shift amount.
module alu_operand_queue #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 4,
    parameter int OP_W    = 4,
    parameter int SHAMT_W = $clog2(DATA_W) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [REG_W-1:0]   in_rd,
    input  logic [REG_W-1:0]   in_src_a,
    input  logic [REG_W-1:0]   in_src_b,
    input  logic               in_use_a,
    input  logic               in_use_b,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [DATA_W-1:0]  in_b,
    input  logic               fwd_valid,
    input  logic [REG_W-1:0]   fwd_rd,
    input  logic [DATA_W-1:0]  fwd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    out_op,
    output logic [REG_W-1:0]   out_rd,
    output logic [DATA_W-1:0]  out_a,
    output logic [DATA_W-1:0]  out_b,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic               out_b_zero
);

    logic [OP_W-1:0]   e_op    [2];
    logic [REG_W-1:0]  e_rd    [2];
    logic [REG_W-1:0]  e_src_a [2];
    logic [REG_W-1:0]  e_src_b [2];
    logic              e_use_a [2];
    logic              e_use_b [2];
    logic [DATA_W-1:0] e_a     [2];
    logic [DATA_W-1:0] e_b     [2];

    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic [1:0] slot_valid;
    logic       enq;
    logic       deq;
    logic       fwd_en;

    function automatic logic [DATA_W-1:0] snoop(
        input logic              en,
        input logic [REG_W-1:0]  fwd_reg,
        input logic [DATA_W-1:0] fwd_val,
        input logic              use_reg,
        input logic [REG_W-1:0]  src,
        input logic [DATA_W-1:0] cur
    );
        return (en && use_reg && (src == fwd_reg)) ? fwd_val : cur;
    endfunction

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign fwd_en    = fwd_valid && (fwd_rd != '0);
    assign enq       = in_valid && in_ready && !flush;
    assign deq       = out_valid && out_ready;

    always_comb begin
        // NOTE: default first so every path assigns slot_valid and no latch is inferred.
        slot_valid = 2'b00;
        if (count == 2'd2)
            slot_valid = 2'b11;
        else if (count == 2'd1)
            slot_valid[rd_ptr] = 1'b1;
    end

    // Data outputs are forced to zero while the queue is empty.
    assign out_op     = out_valid ? e_op[rd_ptr] : '0;
    assign out_rd     = out_valid ? e_rd[rd_ptr] : '0;
    assign out_a      = out_valid ? e_a[rd_ptr]  : '0;
    assign out_b      = out_valid ? e_b[rd_ptr]  : '0;
    assign out_b_zero = (out_b == '0);

    always_comb begin
        out_shamt = '0;
        // Scanning downward lets the lowest set bit win.
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (out_b[i])
                out_shamt = SHAMT_W'(i + 1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every entry sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            // NOTE: entry storage is reset as well because reset must zero every field, not just the pointers.
            for (int i = 0; i < 2; i++) begin
                e_op[i]    <= '0;
                e_rd[i]    <= '0;
                e_src_a[i] <= '0;
                e_src_b[i] <= '0;
                e_use_a[i] <= 1'b0;
                e_use_b[i] <= 1'b0;
                e_a[i]     <= '0;
                e_b[i]     <= '0;
            end
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (slot_valid[i]) begin
                    e_a[i] <= snoop(fwd_en, fwd_rd, fwd_data, e_use_a[i], e_src_a[i], e_a[i]);
                    e_b[i] <= snoop(fwd_en, fwd_rd, fwd_data, e_use_b[i], e_src_b[i], e_b[i]);
                end
            end
            // The write slot is never a valid slot, so it cannot collide with the snoop above.
            if (enq) begin
                e_op[wr_ptr]    <= in_op;
                e_rd[wr_ptr]    <= in_rd;
                e_src_a[wr_ptr] <= in_src_a;
                e_src_b[wr_ptr] <= in_src_b;
                e_use_a[wr_ptr] <= in_use_a;
                e_use_b[wr_ptr] <= in_use_b;
                e_a[wr_ptr]     <= snoop(fwd_en, fwd_rd, fwd_data, in_use_a, in_src_a, in_a);
                e_b[wr_ptr]     <= snoop(fwd_en, fwd_rd, fwd_data, in_use_b, in_src_b, in_b);
                wr_ptr          <= ~wr_ptr;
            end
            if (deq)
                rd_ptr <= ~rd_ptr;
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_queue.sv
// Self-checking bench for alu_operand_queue: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_alu_operand_queue;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 4;
    localparam int OP_W    = 4;
    localparam int SHAMT_W = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [OP_W-1:0]    in_op;
    logic [REG_W-1:0]   in_rd;
    logic [REG_W-1:0]   in_src_a;
    logic [REG_W-1:0]   in_src_b;
    logic               in_use_a;
    logic               in_use_b;
    logic [DATA_W-1:0]  in_a;
    logic [DATA_W-1:0]  in_b;
    logic               fwd_valid;
    logic [REG_W-1:0]   fwd_rd;
    logic [DATA_W-1:0]  fwd_data;
    logic               out_valid;
    logic               out_ready;
    logic [OP_W-1:0]    out_op;
    logic [REG_W-1:0]   out_rd;
    logic [DATA_W-1:0]  out_a;
    logic [DATA_W-1:0]  out_b;
    logic [SHAMT_W-1:0] out_shamt;
    logic               out_b_zero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  rd;
        logic              use_a;
        logic [REG_W-1:0]  src_a;
        logic [DATA_W-1:0] a;
        logic              use_b;
        logic [REG_W-1:0]  src_b;
        logic [DATA_W-1:0] b;
    } entry_t;

    entry_t mq[$];

    alu_operand_queue #(
        .DATA_W(DATA_W), .REG_W(REG_W), .OP_W(OP_W), .SHAMT_W(SHAMT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_src_a(in_src_a), .in_src_b(in_src_b), .in_use_a(in_use_a), .in_use_b(in_use_b),
        .in_a(in_a), .in_b(in_b),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd),
        .out_a(out_a), .out_b(out_b), .out_shamt(out_shamt), .out_b_zero(out_b_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] fwd_val(input logic use_r, input logic [REG_W-1:0] src,
                                                  input logic [DATA_W-1:0] cur);
        if (fwd_valid && fwd_rd != 0 && use_r && src == fwd_rd) return fwd_data;
        return cur;
    endfunction

    // Lowest set bit isolated arithmetically, then its position counted from 1.
    function automatic int ref_shamt(input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] low;
        if (b == 0) return 0;
        low = b & (~b + 1);
        return $clog2(low) + 1;
    endfunction

    task automatic model_edge();
        logic   enq;
        logic   deq;
        entry_t e;
        enq = in_valid && (mq.size() < 2) && !flush;
        deq = (mq.size() > 0) && out_ready;
        if (flush) begin
            mq.delete();
        end else begin
            foreach (mq[i]) begin
                mq[i].a = fwd_val(mq[i].use_a, mq[i].src_a, mq[i].a);
                mq[i].b = fwd_val(mq[i].use_b, mq[i].src_b, mq[i].b);
            end
            if (deq) void'(mq.pop_front());
            if (enq) begin
                e.op = in_op; e.rd = in_rd;
                e.use_a = in_use_a; e.src_a = in_src_a; e.a = fwd_val(in_use_a, in_src_a, in_a);
                e.use_b = in_use_b; e.src_b = in_src_b; e.b = fwd_val(in_use_b, in_src_b, in_b);
                mq.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_op = 0; in_rd = 0; in_src_a = 0; in_src_b = 0;
        in_use_a = 0; in_use_b = 0; in_a = 0; in_b = 0;
        fwd_valid = 0; fwd_rd = 0; fwd_data = 0;
    endtask

    task automatic offer(input logic [OP_W-1:0] op, input logic [REG_W-1:0] rd,
                         input logic ua, input logic [REG_W-1:0] sa, input logic [DATA_W-1:0] a,
                         input logic ub, input logic [REG_W-1:0] sb, input logic [DATA_W-1:0] b);
        in_valid = 1; in_op = op; in_rd = rd;
        in_use_a = ua; in_src_a = sa; in_a = a;
        in_use_b = ub; in_src_b = sb; in_b = b;
    endtask

    task automatic test_reset();
        rst = 1; out_ready = 0;
        idle_inputs();
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if ({out_op, out_rd, out_a, out_b, out_shamt} !== '0) begin bad++;
            $display("FAIL reset_data: got op=%h rd=%h a=%h b=%h sh=%0d want all 0", out_op, out_rd, out_a, out_b, out_shamt); end
        total++; if (out_b_zero !== 1'b1) begin bad++; $display("FAIL reset_b_zero: got %b want 1", out_b_zero); end
        #1 rst = 0;
        mq.delete();
    endtask

    task automatic test_single();
        out_ready = 1;
        offer(4'h3, 4'h2, 0, 0, 32'h0000_0003, 0, 0, 32'h0000_0008);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_no_bypass: got out_valid=%b want 0", out_valid); end
        tick();
        in_valid = 0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
        total++; if (out_shamt !== 6'd4) begin bad++; $display("FAIL single_shamt: got %0d want 4", out_shamt); end
        total++; if (out_b_zero !== 1'b0) begin bad++; $display("FAIL single_b_zero: got %b want 0", out_b_zero); end
        total++; if (out_a !== 32'h3 || out_op !== 4'h3) begin bad++; $display("FAIL single_data: got a=%h op=%h want 3/3", out_a, out_op); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_dequeued: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_shamt();
        logic [DATA_W-1:0] bv [4];
        int                exp_sh [4];
        bv = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFF0};
        exp_sh = '{0, 1, 32, 5};
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            offer(4'h1, 4'h1, 0, 0, 32'h55, 0, 0, bv[k]);
            tick();
            in_valid = 0;
            total++; if (out_valid !== 1'b1 || out_b !== bv[k]) begin bad++;
                $display("FAIL shamt_head_%0d: got valid=%b b=%h want 1/%h", k, out_valid, out_b, bv[k]); end
            total++; if (out_shamt !== SHAMT_W'(exp_sh[k])) begin bad++;
                $display("FAIL shamt_%0d: got %0d want %0d", k, out_shamt, exp_sh[k]); end
            total++; if (out_b_zero !== (k == 0)) begin bad++;
                $display("FAIL shamt_bzero_%0d: got %b want %b", k, out_b_zero, (k == 0)); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [OP_W-1:0] got[$];
        logic            accepted;
        out_ready = 0;
        offer(4'h1, 4'h1, 0, 0, 32'hA1, 0, 0, 32'h1);
        tick();
        offer(4'h2, 4'h2, 0, 0, 32'hA2, 0, 0, 32'h2);
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full: got in_ready=%b want 0", in_ready); end
        offer(4'h3, 4'h3, 0, 0, 32'hA3, 0, 0, 32'h4);
        tick();
        total++; if (out_op !== 4'h1 || out_a !== 32'hA1) begin bad++;
            $display("FAIL bp_hold: got op=%h a=%h want 1/a1", out_op, out_a); end
        out_ready = 1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (out_valid && out_ready) got.push_back(out_op);
            accepted = in_valid && in_ready;
            tick();
            if (accepted) in_valid = 0;
            if (got.size() >= 3 && !out_valid) break;
        end
        total++; if (got.size() != 3) begin bad++; $display("FAIL bp_count: got %0d ops want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++; if (got[i] !== OP_W'(i + 1)) begin bad++; $display("FAIL bp_order_%0d: got %h want %0d", i, got[i], i + 1); end
        end
    endtask

    task automatic test_forwarding();
        out_ready = 0;
        offer(4'h5, 4'h7, 1, 4'd5, 32'h1111_1111, 0, 0, 32'h10);
        tick();
        in_valid = 0;
        fwd_valid = 1; fwd_rd = 4'd5; fwd_data = 32'hDEAD_BEEF;
        total++; if (out_a !== 32'h1111_1111) begin bad++; $display("FAIL fwd_before: got %h want 11111111", out_a); end
        tick();
        total++; if (out_a !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fwd_hit: got %h want deadbeef", out_a); end
        fwd_valid = 0; flush = 1; tick(); flush = 0;

        offer(4'h5, 4'h7, 1, 4'd0, 32'h1111_1111, 0, 0, 32'h10);
        tick();
        in_valid = 0;
        fwd_valid = 1; fwd_rd = 4'd0; fwd_data = 32'h1234_5678;
        tick();
        total++; if (out_a !== 32'h1111_1111) begin bad++; $display("FAIL fwd_r0: got %h want 11111111", out_a); end
        fwd_valid = 0; flush = 1; tick(); flush = 0;

        offer(4'h5, 4'h7, 0, 4'd5, 32'h2222_2222, 0, 0, 32'h10);
        tick();
        in_valid = 0;
        fwd_valid = 1; fwd_rd = 4'd5; fwd_data = 32'hCAFE_F00D;
        tick();
        total++; if (out_a !== 32'h2222_2222) begin bad++; $display("FAIL fwd_unused: got %h want 22222222", out_a); end
        fwd_valid = 0; flush = 1; tick(); flush = 0;

        offer(4'h6, 4'h1, 0, 0, 32'h1, 1, 4'd9, 32'h0000_FFFF);
        fwd_valid = 1; fwd_rd = 4'd9; fwd_data = 32'h0000_0100;
        tick();
        in_valid = 0; fwd_valid = 0;
        total++; if (out_b !== 32'h100 || out_shamt !== 6'd9) begin bad++;
            $display("FAIL fwd_enqueue_b: got b=%h sh=%0d want 100/9", out_b, out_shamt); end
        flush = 1; tick(); flush = 0;
    endtask

    task automatic test_flush();
        out_ready = 0;
        offer(4'h6, 4'h1, 0, 0, 32'h6, 0, 0, 32'h6);
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre: got out_valid=%b want 1", out_valid); end
        offer(4'hA, 4'h1, 0, 0, 32'hA, 0, 0, 32'hA);
        flush = 1;
        tick();
        flush = 0; in_valid = 0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
            $display("FAIL flush_empty: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop: got out_valid=%b op=%h want 0", out_valid, out_op); end
    endtask

    task automatic test_random();
        entry_t            h;
        logic              e_valid;
        logic [OP_W-1:0]   e_op;
        logic [REG_W-1:0]  e_rd;
        logic [DATA_W-1:0] e_a;
        logic [DATA_W-1:0] e_b;
        logic [DATA_W-1:0] rb;
        for (int cyc = 0; cyc < 400; cyc++) begin
            case ($urandom % 4)
                0:       rb = 0;
                1:       rb = 32'h1 << ($urandom % 32);
                default: rb = $urandom;
            endcase
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 25) == 0;
            in_op = OP_W'($urandom); in_rd = REG_W'($urandom);
            in_use_a = $urandom % 2; in_src_a = REG_W'($urandom_range(0, 3)); in_a = $urandom;
            in_use_b = $urandom % 2; in_src_b = REG_W'($urandom_range(0, 3)); in_b = rb;
            fwd_valid = $urandom % 2; fwd_rd = REG_W'($urandom_range(0, 3)); fwd_data = $urandom;

            e_valid = mq.size() > 0;
            if (e_valid) begin
                h = mq[0];
                e_op = h.op; e_rd = h.rd; e_a = h.a; e_b = h.b;
            end else begin
                e_op = 0; e_rd = 0; e_a = 0; e_b = 0;
            end
            total++; if (in_ready !== (mq.size() < 2)) begin bad++;
                $display("FAIL rnd_in_ready@%0d: got %b want %b", cyc, in_ready, mq.size() < 2); end
            total++; if (out_valid !== e_valid) begin bad++;
                $display("FAIL rnd_out_valid@%0d: got %b want %b", cyc, out_valid, e_valid); end
            total++; if (out_op !== e_op || out_rd !== e_rd) begin bad++;
                $display("FAIL rnd_op_rd@%0d: got %h/%h want %h/%h", cyc, out_op, out_rd, e_op, e_rd); end
            total++; if (out_a !== e_a || out_b !== e_b) begin bad++;
                $display("FAIL rnd_ab@%0d: got %h/%h want %h/%h", cyc, out_a, out_b, e_a, e_b); end
            total++; if (out_shamt !== SHAMT_W'(ref_shamt(e_b)) || out_b_zero !== (e_b == 0)) begin bad++;
                $display("FAIL rnd_shamt@%0d: got %0d/%b want %0d/%b", cyc, out_shamt, out_b_zero, ref_shamt(e_b), e_b == 0); end
            tick();
        end
        idle_inputs();
        flush = 1; tick(); flush = 0;
    endtask

    task automatic test_reset_midstream();
        out_ready = 0;
        offer(4'h1, 4'h1, 0, 0, 32'h11, 0, 0, 32'h3);
        tick();
        offer(4'h2, 4'h2, 0, 0, 32'h22, 0, 0, 32'h5);
        tick();
        in_valid = 0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_full: got in_ready=%b want 0", in_ready); end
        #2 rst = 1;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
            $display("FAIL rstmid_flags: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
        total++; if ({out_op, out_rd, out_a, out_b, out_shamt} !== '0 || out_b_zero !== 1'b1) begin bad++;
            $display("FAIL rstmid_data: got a=%h b=%h sh=%0d bz=%b want 0/0/0/1", out_a, out_b, out_shamt, out_b_zero); end
        rst = 0;
        mq.delete();
        offer(4'hC, 4'h3, 0, 0, 32'h5, 0, 0, 32'h0);
        tick();
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || out_op !== 4'hC || out_a !== 32'h5) begin bad++;
            $display("FAIL rstmid_enqueue: got valid=%b op=%h a=%h want 1/c/5", out_valid, out_op, out_a); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_shamt();
        test_back_to_back();
        test_forwarding();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_queue.md
# alu_operand_queue

Two-entry operand staging queue between the decode stage and the execute-stage ALU units (SHFL, adders, logic units). Each accepted operation is buffered and its register operands are refreshed from the execute result-forwarding bus while it waits. The head entry is presented to the ALU with a precomputed SHFL shift amount: lowest set bit of B, counted from 1. Valid/ready handshakes decouple the stage from decode on the input side and from the ALU on the output side.

## Interface
- DATA_W, 32, operand width; equals width of `definitions::t_data`
- REG_W, 4, register-index width
- OP_W, 4, ALU opcode width
- SHAMT_W, $clog2(DATA_W)+1, shift-amount width (6 at default)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous pipeline flush (branch taken)
- in_valid  in  1  decode offers an operation
- in_ready  out  1  queue can accept
- in_op  in  OP_W  ALU opcode
- in_rd  in  REG_W  destination register
- in_src_a / in_src_b  in  REG_W  source register indices
- in_use_a / in_use_b  in  1  operand comes from a register (forwardable)
- in_a / in_b  in  DATA_W  operand values read from the register file
- fwd_valid  in  1  execute stage is writing a result this cycle
- fwd_rd  in  REG_W  register being written
- fwd_data  in  DATA_W  value being written
- out_valid  out  1  head entry valid
- out_ready  in  1  ALU accepts head
- out_op, out_rd  out  OP_W, REG_W  head opcode and destination
- out_a, out_b  out  DATA_W  head operands
- out_shamt  out  SHAMT_W  (index of lowest '1' in out_b)+1; 0 when out_b==0
- out_b_zero  out  1  out_b==0

## Operation
- Storage: 2-entry circular buffer. State: wr_ptr, rd_ptr (1 bit each) and count (0..2).
- Enqueue when in_valid && in_ready. Dequeue when out_valid && out_ready.
- in_ready = (count<2). It depends only on state and never on out_ready.
- out_valid = (count>0). When count==0, out_op, out_rd, out_a, out_b and out_shamt are 0 and out_b_zero is 1.
- Simultaneous enqueue and dequeue leaves count unchanged and advances both pointers.
- Forwarding snoop, evaluated every cycle for every valid stored entry:
  - If fwd_valid && fwd_rd!=0 && use_a && src_a==fwd_rd, set a<=fwd_data. Operand b follows the same rule.
  - The same rule applies to the entry being enqueued. The forwarded value replaces in_a/in_b.
  - Register 0 is never forwarded.
  - A dequeuing entry needs no update.
- Shift amount is combinational from the head entry's b using a priority encoder from bit 0. B=0x1 gives 1. B=0x8000_0000 gives 32. The consumer shifts A left by out_shamt, and B==0 means pass A unchanged.
- Flush: at the next edge, count, wr_ptr and rd_ptr go to 0. Flush takes priority over a same-cycle enqueue, which is dropped (decode must not count it as accepted), and over a same-cycle dequeue. in_ready stays per count, so the dropped handshake is the only effect.
- Reset: count, pointers and all entry fields go to 0 immediately. out_valid=0, in_ready=1, all data outputs 0, out_b_zero=1.

## Timing
- Latency: an op enqueued at edge N is visible on out_* after edge N. The earliest ALU accept is at edge N+1. There is no same-cycle input-to-output bypass.
- Throughput: one op per cycle while out_ready is held high (count steady at 1).
- Forwarding: a fwd_data seen at edge N is reflected on out_a/out_b after edge N. out_shamt and out_b_zero follow out_b in the same cycle.
- Output stability: out_* holds steady while out_valid && !out_ready, except for forwarding updates. A forwarding update is legal because the ALU has not accepted the entry.
- Rst assertion mid-operation discards all entries asynchronously. After deassertion, the first enqueue can occur at the next edge.

## Test plan
- Reset mid-stream with count==2: assert rst between edges. out_valid drops and in_ready rises without a clock edge. All outputs are 0 and out_b_zero=1.
- Single op A=0x0000_0003, B=0x0000_0008, in_use_b=0, out_ready=1. Accepted at edge N. After edge N: out_valid=1, out_shamt=4, out_b_zero=0. Dequeued at N+1.
- Shift-amount corners: B=0 gives shamt 0 and b_zero 1. B=0x1 gives 1. B=0x8000_0000 gives 32. B=0xFFFF_FFF0 gives 5.
- Backpressure: out_ready=0, offer ops X, Y, Z on consecutive cycles. in_ready=0 after Y, so Z is held. Raise out_ready: outputs are X, Y, Z in order, with no loss or duplicate.
- Forwarding: buffer an entry with use_a=1, src_a=5, a=0x1111_1111, out_ready=0. Drive fwd_valid=1, fwd_rd=5, fwd_data=0xDEAD_BEEF: out_a becomes 0xDEAD_BEEF next cycle. Repeat with fwd_rd=0 or use_a=0: out_a is unchanged.
- Flush with simultaneous in_valid=1 and count==1: after the edge count==0 and out_valid=0. The flushed-cycle op never appears at the output.
